jpeg_bit_packer: RTL and testbench
==================================

// Module: jpeg_bit_packer
// PURPOSE
//  Packs variable-length Huffman codes (DC and AC) from the Huffman encode controller into a JPEG entropy-coded byte stream.
//  Inserts 0x00 after every 0xFF data byte, pads the final byte with 1s on flush, and can append the EOI marker.
//  Sits directly downstream of the encoder top (huffman_code / huffman_code_length) and feeds the file/host writer.
// PARAMETERS
//  MAX_CODE_W  24  widest code accepted per beat (DC: category code + amplitude bits)
//  ACC_W       40  bit accumulator width; must be >= MAX_CODE_W + 8
//  EMIT_EOI    1   1: append FF D9 after flush padding; 0: flush stops after padding
// PORTS
//  clock       in   1    single clock, rising edge
//  reset       in   1    synchronous, active-high
//  code_valid  in   1    code beat valid
//  code_ready  out  1    beat accepted when code_valid && code_ready
//  code_bits   in   24   code, right-aligned, MSB sent first; bits above code_len ignored
//  code_len    in   5    valid bit count, 0..MAX_CODE_W
//  flush_req   in   1    1-cycle pulse: close stream (pad, optional EOI)
//  flush_done  out  1    1-cycle pulse when the last flush byte has been transferred
//  out_valid   out  1    out_byte valid
//  out_ready   in   1    downstream accepts when out_valid && out_ready
//  out_byte    out  8    stream byte
//  byte_count  out  32   bytes transferred since reset, including stuffed and marker bytes
//  err_len     out  1    sticky: beat received with code_len > MAX_CODE_W
// BEHAVIOUR
//  Reset: code_ready=0, out_valid=0, out_byte=0, flush_done=0, byte_count=0, err_len=0, bit_cnt=0, state=RUN.
//   code_ready rises the first cycle after reset deasserts. Reset mid-stream discards all pending bits and any pending stuff byte.
//  Accumulator acc[ACC_W-1:0], MSB-aligned. bit_cnt = number of valid bits.
//   On accept: bits are appended directly below the existing bits, then bit_cnt += code_len.
//  code_ready = (state==RUN) && (bit_cnt <= ACC_W-MAX_CODE_W). It is registered and computed from next-state values.
//  code_len=0: beat accepted, no-op.
//   code_len>MAX_CODE_W: beat accepted and dropped, err_len set (cleared only by reset).
//  Output register: when slot free (!out_valid or transfer this cycle) and bit_cnt>=8, load acc top byte and shift acc left 8 bits.
//   Latency: a code completing a byte shows on out_byte the next cycle.
//   out_byte/out_valid are held stable while out_valid && !out_ready.
//  Same-cycle accept and byte load are allowed; net bit_cnt = bit_cnt + code_len - 8.
//  Stuffing: when a data byte 0xFF transfers, the next byte loaded is 0x00.
//   The stuff byte has priority over accumulator bytes; markers are never stuffed.
//  States:
//   RUN    normal operation; flush_req -> PAD (code_ready drops the next cycle; beats are no longer taken).
//   PAD    if bit_cnt%8 != 0, fill with 1s to the next byte boundary (one cycle). Go to DRAIN.
//   DRAIN  emit the remaining bytes and any pending stuff byte. When bit_cnt==0 and the slot is free -> EOI (EMIT_EOI) else DONE.
//   EOI    load 0xFF, then 0xD9, each after the previous byte transfers. After the D9 transfer -> DONE.
//   DONE   pulse flush_done 1 cycle -> RUN.
//  flush_req with an empty accumulator and EMIT_EOI=0: flush_done is asserted 2 cycles later.
//  flush_req outside RUN is ignored. code_valid during flush is not accepted.
//  byte_count increments on every out_valid && out_ready, and wraps at 2^32.
// STRUCTURE
//  jpeg_pkg holds:
//   - markers: MRK_FF=8'hFF, MRK_EOI=8'hD9, STUFF_00=8'h00
//   - pk_state_t enum {RUN,PAD,DRAIN,EOI,DONE}
//   - the MAX_CODE_W/ACC_W defaults
//  One sub-module: jpeg_byte_stuffer. It owns the output register, the valid/ready hold, 0xFF->0x00 insertion and byte_count.
//   It takes a byte plus an is_marker flag from the packer core.
// TESTING
//  1 Pack: (0b101,len3),(0b10011,len5) -> single byte 0xB3 one cycle after the 2nd accept; byte_count=1.
//  2 Stuff: (16'hFFFF,len16) -> bytes FF,00,FF,00; byte_count=4.
//  3 Flush: (0b010,len3), flush_req, EMIT_EOI=1 -> 0x5F, FF, D9 (no 00 after the marker FF), then flush_done pulse.
//  4 Backpressure: out_ready=0 for 10 cycles under back-to-back len-16 codes.
//    - code_ready drops once bit_cnt>16
//    - out_byte stays stable while held
//    - full stream matches the reference model with no loss
//  5 Reset mid-stream: 20 bits pending, reset 1 cycle -> out_valid=0, byte_count=0, code_ready=1 next cycle.
//    Next codes pack from bit 0.
//  6 Error: code_len=25 -> err_len=1 and no bytes. A following (8'hA5,len8) -> 0xA5 and err_len stays 1.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: marker bytes, packer state type and default widths for the JPEG bit packer
package jpeg_pkg;
  localparam logic [7:0] MRK_FF = 8'hFF;
  localparam logic [7:0] MRK_EOI = 8'hD9;
  localparam logic [7:0] STUFF_00 = 8'h00;
  localparam int MAX_CODE_W_D = 24;
  localparam int ACC_W_D = 40;
  typedef enum logic [2:0] {RUN, PAD, DRAIN, EOI, DONE} pk_state_t;
endpackage

// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer: output byte register (in_valid/in_byte/in_marker -> out_valid/out_byte) with 0xFF->0x00 insertion, valid/ready hold and byte_count
module jpeg_byte_stuffer import jpeg_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_marker,
  output logic        ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [31:0] byte_count
);
  logic mark, xfer, free, stuff;
  always_comb begin
    xfer = out_valid && out_ready;
    free = !out_valid || xfer;
    stuff = xfer && out_byte == MRK_FF && !mark;
    ready = free && !stuff;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_byte <= 8'h00;
      mark <= 1'b0;
      byte_count <= 32'd0;
    end else begin
      if (xfer) byte_count <= byte_count + 32'd1;
      if (stuff) begin
        out_valid <= 1'b1;
        out_byte <= STUFF_00;
        mark <= 1'b0;
      end else if (ready && in_valid) begin
        out_valid <= 1'b1;
        out_byte <= in_byte;
        mark <= in_marker;
      end else if (xfer) out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs right-aligned Huffman codes (code_*) into a stuffed JPEG byte stream (out_*), with flush padding, optional EOI, byte_count and err_len
module jpeg_bit_packer import jpeg_pkg::*; #(
  parameter int MAX_CODE_W = MAX_CODE_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter bit EMIT_EOI = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              code_valid,
  output logic                              code_ready,
  input  logic [MAX_CODE_W-1:0]             code_bits,
  input  logic [$clog2(MAX_CODE_W+1)-1:0]   code_len,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        out_byte,
  output logic [31:0]                       byte_count,
  output logic                              err_len
);
  localparam int CW = $clog2(ACC_W + 1);
  pk_state_t state, nstate;
  logic [ACC_W-1:0] acc, acc_n, a1, cw, placed, padm;
  logic [CW-1:0] cnt, cnt_n, c1, rnd;
  logic [1:0] eoi_n;
  logic rdy, ld_data, ld_mark, accept, len_ok;
  logic [7:0] in_byte;
  pk_state_t fin;
  always_comb begin
    fin = EMIT_EOI ? EOI : DONE;
    accept = code_valid && code_ready;
    len_ok = code_len <= MAX_CODE_W;
    ld_data = (state == RUN || state == DRAIN) && cnt >= CW'(8) && rdy;
    ld_mark = state == EOI && eoi_n < 2'd2 && rdy;
    in_byte = ld_mark ? (eoi_n == 2'd0 ? MRK_FF : MRK_EOI) : acc[ACC_W-1 -: 8];
    a1 = ld_data ? acc << 8 : acc;
    c1 = ld_data ? cnt - CW'(8) : cnt;
    cw = ACC_W'(code_bits) & ~({ACC_W{1'b1}} << code_len);
    placed = (cw << (ACC_W - int'(code_len))) >> c1;
    rnd = (cnt + CW'(7)) & ~CW'(7);
    padm = ({ACC_W{1'b1}} >> cnt) & ~({ACC_W{1'b1}} >> rnd);
    acc_n = state == PAD ? acc | padm : (accept && len_ok ? a1 | placed : a1);
    cnt_n = state == PAD ? rnd : (accept && len_ok ? c1 + CW'(code_len) : c1);
    nstate = state == RUN ? (flush_req ? PAD : RUN) :
             state == PAD ? (rnd == '0 && rdy ? fin : DRAIN) :
             state == DRAIN ? (cnt == '0 && rdy ? fin : DRAIN) :
             state == EOI ? (eoi_n == 2'd2 && rdy ? DONE : EOI) : RUN;
    flush_done = state == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      acc <= '0;
      cnt <= '0;
      code_ready <= 1'b0;
      err_len <= 1'b0;
      eoi_n <= 2'd0;
    end else begin
      state <= nstate;
      acc <= acc_n;
      cnt <= cnt_n;
      code_ready <= nstate == RUN && cnt_n <= CW'(ACC_W - MAX_CODE_W);
      if (accept && !len_ok) err_len <= 1'b1;
      eoi_n <= state != EOI ? 2'd0 : eoi_n + 2'(ld_mark);
    end
  end
  jpeg_byte_stuffer u_stuff (
    .clock(clock),
    .reset(reset),
    .in_valid(ld_data || ld_mark),
    .in_byte(in_byte),
    .in_marker(ld_mark),
    .ready(rdy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte(out_byte),
    .byte_count(byte_count)
  );
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: randomized self-checking bench against a bit-queue stream model
module tb_jpeg_bit_packer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic code_valid = 1'b0;
  logic flush_req = 1'b0;
  logic out_ready = 1'b1;
  logic [23:0] code_bits = '0;
  logic [4:0] code_len = '0;
  logic code_ready, flush_done, out_valid, err_len;
  logic [7:0] out_byte;
  logic [31:0] byte_count;
  logic or_fixed = 1'b1;
  logic or_rand = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int m_cnt = 0;
  logic m_err = 1'b0;
  bit bits[$];
  logic [7:0] exp_q[$];
  jpeg_bit_packer dut (
    .clock(clock), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
    .code_bits(code_bits), .code_len(code_len), .flush_req(flush_req), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .byte_count(byte_count), .err_len(err_len)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    #1;
    out_ready = or_rand ? 1'($urandom_range(0, 1)) : or_fixed;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic mdrain();
    logic [7:0] b;
    while (bits.size() >= 8) begin
      for (int i = 0; i < 8; i++) b = {b[6:0], 1'(bits.pop_front())};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask
  always @(negedge clock) begin
    if (reset) begin
      bits.delete();
      exp_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (code_valid && code_ready) begin
        if (code_len > 5'd24) m_err = 1'b1;
        else for (int i = int'(code_len) - 1; i >= 0; i--) bits.push_back(code_bits[i]);
        mdrain();
      end
      if (flush_req) begin
        while (bits.size() % 8 != 0) bits.push_back(1'b1);
        mdrain();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
      end
      if (out_valid && out_ready) begin
        m_cnt++;
        chk("stream_has_byte", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("byte", out_byte, exp_q.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [23:0] b, input logic [4:0] l);
    bit ok = 0;
    code_valid = 1'b1;
    code_bits = b;
    code_len = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      ok = code_ready;
    end
    if (!ok) chk("send_timeout", 0, 1);
    step();
    code_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int i;
    for (i = 0; i < 500 && (exp_q.size() != 0 || out_valid); i++) step();
    chk("idle_timeout", 64'(i < 500), 1);
  endtask
  task automatic flush_and_wait();
    bit seen = 0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("flush_ready_low", code_ready, 0);
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clock);
      seen = flush_done;
    end
    chk("flush_done", seen, 1);
    @(negedge clock);
    chk("flush_done_pulse", flush_done, 0);
    chk("flush_queue_empty", exp_q.size(), 0);
    step();
  endtask
  initial begin
    logic [31:0] bc0;
    logic [7:0] held;
    bit held_set, acc_now;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_err", err_len, 0);
    chk("rst_code_ready", code_ready, 0);
    chk("rst_flush_done", flush_done, 0);
    reset = 1'b0;
    step();
    chk("ready_after_rst", code_ready, 1);
    send(24'h5, 5'd3);
    send(24'h13, 5'd5);
    step();
    chk("pack_valid", out_valid, 1);
    chk("pack_byte", out_byte, 8'hB3);
    step();
    chk("pack_count", byte_count, 1);
    bc0 = byte_count;
    send(24'hFFFF, 5'd16);
    wait_idle();
    chk("stuff_count", byte_count, bc0 + 4);
    bc0 = byte_count;
    send(24'h2, 5'd3);
    flush_and_wait();
    chk("flush_count", byte_count, bc0 + 3);
    or_fixed = 1'b0;
    step();
    code_valid = 1'b1;
    code_len = 5'd16;
    code_bits = 24'($urandom);
    held_set = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (out_valid) begin
        if (!held_set) begin
          held = out_byte;
          held_set = 1;
        end else chk("bp_hold", out_byte, held);
      end
      acc_now = code_ready;
      step();
      if (acc_now) code_bits = 24'($urandom);
    end
    chk("bp_ready_low", code_ready, 0);
    chk("bp_held_valid", out_valid, 1);
    code_valid = 1'b0;
    or_fixed = 1'b1;
    for (int n = 0; n < 6; n++) send(24'($urandom), 5'd16);
    flush_and_wait();
    chk("bp_count", byte_count, m_cnt);
    send(24'($urandom), 5'd20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", byte_count, 0);
    step();
    chk("mid_rst_ready", code_ready, 1);
    send(24'h3C, 5'd8);
    step();
    chk("mid_rst_byte", out_byte, 8'h3C);
    wait_idle();
    send(24'h123, 5'd25);
    step();
    step();
    chk("err_set", err_len, 1);
    chk("err_no_bytes", byte_count, 1);
    send(24'hA5, 5'd8);
    step();
    chk("err_next_byte", out_byte, 8'hA5);
    wait_idle();
    chk("err_sticky", err_len, 1);
    or_rand = 1'b1;
    for (int n = 0; n < 60; n++) send(24'($urandom), 5'($urandom_range(0, 24)));
    flush_and_wait();
    or_rand = 1'b0;
    step();
    chk("rand_count", byte_count, m_cnt);
    chk("rand_err", err_len, m_err);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
